// File: rtl/freq_div_pkg.sv
// Shared types and helpers for the programmable rate divider.
// Covers the FSM states, the output modes and the square-wave half-period.
package freq_div_pkg;

  typedef enum logic {IDLE, RUN} fd_state_t;
  typedef enum logic {SQUARE, PULSE} fd_mode_t;

  // High phase length ceil(n/2); one extra bit so n = all-ones cannot overflow.
  function automatic logic [32:0] half_period(input logic [31:0] n);
    return (33'(n) + 33'd1) >> 1;
  endfunction

endpackage

// File: rtl/freq_div_prog.sv
// Programmable synchronous divider producing a square or single-pulse enable.
// Divisor changes made while running wait for the next period boundary.
module freq_div_prog
  import freq_div_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             init,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] div,
  output logic             o,
  output logic             tick,
  output logic             pend
);

  // Handshake: load is a single-cycle strobe with div valid in the same cycle;
  // there is no ready, every strobe is accepted (a newer one overwrites a pending one).

  fd_state_t        state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] div_r, div_r_n;
  logic [WIDTH-1:0] div_p, div_p_n;
  logic             pend_r, pend_n;
  logic             last;
  logic             run;
  logic [32:0]      half;
  logic             o_sq;

  assign last = (cnt == div_r - WIDTH'(1));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_r_n = div_r;
    div_p_n = div_p;
    pend_n  = pend_r;
    case (state)
      IDLE: begin
        cnt_n  = '0;
        pend_n = 1'b0;
        if (pend_r) div_r_n = div_p;
        if (load)   div_r_n = div;
        if (en && (div_r_n != '0)) state_n = RUN;
      end
      RUN: begin
        if (!en) begin
          // Stopping applies any waiting divisor so the next start uses it.
          state_n = IDLE;
          cnt_n   = '0;
          pend_n  = 1'b0;
          if (pend_r) div_r_n = div_p;
          if (load)   div_r_n = div;
        end else if (last) begin
          cnt_n = '0;
          if (pend_r) begin
            div_r_n = div_p;
            pend_n  = 1'b0;
            if (div_p == '0) state_n = IDLE;
          end
          // A strobe on the boundary edge waits for the following boundary.
          if (load) begin
            div_p_n = div;
            pend_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt + WIDTH'(1);
          if (load) begin
            div_p_n = div;
            pend_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state  <= IDLE;
      cnt    <= '0;
      div_r  <= WIDTH'(DEF_DIV);
      div_p  <= '0;
      pend_r <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      div_r  <= div_r_n;
      div_p  <= div_p_n;
      pend_r <= pend_n;
    end
  end

  assign run  = (state == RUN);
  assign half = half_period(32'(div_r));
  assign o_sq = run && (33'(cnt) < half);
  assign tick = run && (cnt == '0);
  assign o    = (fd_mode_t'(mode) == PULSE) ? tick : o_sq;
  assign pend = pend_r;

endmodule

// File: tb/tb_freq_div_prog.sv
// Bench for freq_div_prog: directed scenarios plus randomized traffic
// compared against a period-position reference model.
module tb_freq_div_prog;

  logic       clk = 1'b0;
  logic       init, en, mode, load;
  logic [7:0] div;
  logic       o, tick, pend;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit m_run, m_hp;
  int m_pos, m_n, m_next;

  freq_div_prog #(.WIDTH(8), .DEF_DIV(4)) dut (
    .clk(clk), .init(init), .en(en), .mode(mode), .load(load), .div(div),
    .o(o), .tick(tick), .pend(pend)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle_load(input int n);
    en = 1'b0; load = 1'b0;
    step();
    load = 1'b1; div = 8'(n);
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    init = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; div = '0;
    step(); step();
    checks++;
    if (o !== 1'b0 || tick !== 1'b0 || pend !== 1'b0) begin
      errors++;
      $display("FAIL reset: o=%b tick=%b pend=%b required 0 0 0", o, tick, pend);
    end
    init = 1'b0;
  endtask

  task automatic test_div4();
    en = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (o !== ((i % 4) < 2) || tick !== (i % 4 == 0)) begin
        errors++;
        $display("FAIL div4 cyc%0d: o=%b tick=%b required %b %b", i, o, tick, (i % 4) < 2, i % 4 == 0);
      end
      step();
    end
  endtask

  task automatic test_div5();
    en = 1'b0;
    step();
    checks++;
    if (o !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL div5 idle: o=%b tick=%b required 0 0", o, tick);
    end
    load = 1'b1; div = 8'd5;
    step();
    load = 1'b0;
    checks++;
    if (pend !== 1'b0) begin
      errors++;
      $display("FAIL div5 idle_load_pend: pend=%b required 0", pend);
    end
    en = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        mode = 1'b1;
        #1;
      end
      checks++;
      if (i < 10) begin
        if (o !== ((i % 5) < 3) || tick !== (i % 5 == 0)) begin
          errors++;
          $display("FAIL div5 square cyc%0d: o=%b tick=%b required %b %b", i, o, tick, (i % 5) < 3, i % 5 == 0);
        end
      end else if (o !== (i % 5 == 0) || tick !== (i % 5 == 0)) begin
        errors++;
        $display("FAIL div5 pulse cyc%0d: o=%b tick=%b required %b %b", i, o, tick, i % 5 == 0, i % 5 == 0);
      end
      step();
    end
    mode = 1'b0;
  endtask

  task automatic test_change();
    go_idle_load(6);
    en = 1'b1;
    step(); step(); step();        // cnt = 2
    load = 1'b1; div = 8'd3;
    step();
    checks++;
    if (pend !== 1'b1) begin errors++; $display("FAIL change pend_a: pend=%b required 1", pend); end
    div = 8'd7;
    step();
    load = 1'b0;
    checks++;
    if (pend !== 1'b1) begin errors++; $display("FAIL change pend_b: pend=%b required 1", pend); end
    step();
    checks++;
    if (pend !== 1'b1 || tick !== 1'b0) begin
      errors++; $display("FAIL change pre_boundary: pend=%b tick=%b required 1 0", pend, tick);
    end
    step();
    checks++;
    if (pend !== 1'b0 || tick !== 1'b1) begin
      errors++; $display("FAIL change boundary: pend=%b tick=%b required 0 1", pend, tick);
    end
    for (int i = 1; i < 7; i++) begin
      step();
      checks++;
      if (tick !== 1'b0 || o !== (i < 4)) begin
        errors++; $display("FAIL change n7 cyc%0d: o=%b tick=%b required %b 0", i, o, tick, i < 4);
      end
    end
    step();
    checks++;
    if (tick !== 1'b1) begin errors++; $display("FAIL change n7 wrap: tick=%b required 1", tick); end
  endtask

  task automatic test_n1_zero();
    go_idle_load(1);
    en = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        mode = 1'b1;
        #1;
      end
      checks++;
      if (o !== 1'b1 || tick !== 1'b1) begin
        errors++; $display("FAIL n1 cyc%0d: o=%b tick=%b required 1 1", i, o, tick);
      end
      step();
    end
    mode = 1'b0;
    load = 1'b1; div = 8'd0;
    step();
    load = 1'b0;
    checks++;
    if (pend !== 1'b1 || tick !== 1'b1) begin
      errors++; $display("FAIL zero captured: pend=%b tick=%b required 1 1", pend, tick);
    end
    step();
    checks++;
    if (o !== 1'b0 || tick !== 1'b0 || pend !== 1'b0) begin
      errors++; $display("FAIL zero idle: o=%b tick=%b pend=%b required 0 0 0", o, tick, pend);
    end
    step();
    checks++;
    if (o !== 1'b0 || tick !== 1'b0) begin
      errors++; $display("FAIL zero stays_idle: o=%b tick=%b required 0 0", o, tick);
    end
  endtask

  task automatic test_init_mid();
    go_idle_load(8);
    en = 1'b1;
    step(); step();                // cnt = 1
    load = 1'b1; div = 8'd2;
    step();
    load = 1'b0;
    step();                        // cnt = 3
    checks++;
    if (pend !== 1'b1 || o !== 1'b1) begin
      errors++; $display("FAIL init pre: pend=%b o=%b required 1 1", pend, o);
    end
    init = 1'b1;
    step();
    init = 1'b0;
    checks++;
    if (o !== 1'b0 || tick !== 1'b0 || pend !== 1'b0) begin
      errors++; $display("FAIL init post: o=%b tick=%b pend=%b required 0 0 0", o, tick, pend);
    end
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (o !== ((i % 4) < 2) || tick !== (i % 4 == 0)) begin
        errors++; $display("FAIL init restart cyc%0d: o=%b tick=%b required %b %b", i, o, tick, (i % 4) < 2, i % 4 == 0);
      end
      step();
    end
  endtask

  task automatic test_en_glitch();
    go_idle_load(6);
    en = 1'b1;
    step(); step(); step();        // cnt = 2
    en = 1'b0;
    step();
    checks++;
    if (o !== 1'b0 || tick !== 1'b0) begin
      errors++; $display("FAIL glitch low: o=%b tick=%b required 0 0", o, tick);
    end
    en = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (o !== (i < 3) || tick !== (i == 0)) begin
        errors++; $display("FAIL glitch restart cyc%0d: o=%b tick=%b required %b %b", i, o, tick, i < 3, i == 0);
      end
      step();
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_pos = 0; m_n = 4; m_next = 0; m_hp = 1'b0;
  endtask

  task automatic test_random();
    bit exp_t, exp_o;
    init = 1'b1; en = 1'b0; load = 1'b0; mode = 1'b0;
    step();
    init = 1'b0;
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      bit can_load;
      init = ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      can_load = (m_run && en) || (!m_run && !en);
      if (m_run && en && m_pos == m_n - 1 && m_hp && m_next == 0) can_load = 1'b0;
      load = can_load && ($urandom_range(0, 7) == 0);
      div  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 10));
      #1;
      exp_t = m_run && (m_pos == 0);
      exp_o = mode ? exp_t : (m_run && (2 * m_pos < m_n));
      checks++;
      if (o !== exp_o || tick !== exp_t || pend !== m_hp) begin
        errors++;
        $display("FAIL random cyc%0d: o=%b tick=%b pend=%b required %b %b %b", i, o, tick, pend, exp_o, exp_t, m_hp);
      end
      if (init) model_reset();
      else if (!m_run) begin
        if (load) m_n = int'(div);
        if (en && m_n != 0) begin m_run = 1'b1; m_pos = 0; end
      end else if (!en) begin
        m_run = 1'b0; m_pos = 0;
        if (m_hp) m_n = m_next;
        m_hp = 1'b0;
      end else begin
        if (m_pos == m_n - 1) begin
          m_pos = 0;
          if (m_hp) begin
            m_n = m_next; m_hp = 1'b0;
            if (m_n == 0) m_run = 1'b0;
          end
        end else m_pos++;
        if (load) begin m_next = int'(div); m_hp = 1'b1; end
      end
      step();
    end
    init = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_div4();
    test_div5();
    test_change();
    test_n1_zero();
    test_init_mid();
    test_en_glitch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
